hist_readout: RTL and testbench
===============================

HIST_READOUT -- requirements
Module: hist_readout

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one histogram bin count.
REQ-002 Parameter BOUND_NUM, default 32: number of bins.
REQ-003 Parameter BOUND_NUM_WIDTH, default 5: bits needed to hold a bin index 0..BOUND_NUM-1.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start_i, input, 1: snapshot-and-stream request, one-cycle pulse.
REQ-007 Port arr_i, input, DATA_WIDTH*BOUND_NUM: packed histogram; bin i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port max_num_i, input, BOUND_NUM_WIDTH: index of the peak bin from the accumulator.
REQ-009 Port ready_i, input, 1: downstream consumer accepts the current beat.
REQ-010 Port data_val_o, output, 1: current beat valid.
REQ-011 Port data_o, output, DATA_WIDTH: bin count of the current beat.
REQ-012 Port idx_o, output, BOUND_NUM_WIDTH: bin index of the current beat.
REQ-013 Port is_max_o, output, 1: current beat is the peak bin.
REQ-014 Port last_o, output, 1: current beat is bin BOUND_NUM-1.
REQ-015 Port busy_o, output, 1: block is not IDLE.
REQ-016 Port total_o, output, DATA_WIDTH+BOUND_NUM_WIDTH: sum of all streamed bins, held until the next start.
REQ-017 Port done_o, output, 1: one-cycle pulse when the stream completes.
REQ-018 Port clear_o, output, 1: one-cycle pulse to the accumulator's clear input when the stream completes.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, SEND and FINISH.
REQ-020 IDLE with start_i=1: latch all BOUND_NUM bins of arr_i and max_num_i into shadow registers, set idx to 0, clear the running sum, go to SEND.
REQ-021 start_i outside IDLE SHALL be ignored; the shadow registers SHALL stay unchanged during SEND.
REQ-022 In SEND: data_val_o=1, data_o=shadow[idx], idx_o=idx, is_max_o=(idx==latched max), last_o=(idx==BOUND_NUM-1).
REQ-023 Latency: start_i at cycle N gives data_val_o=1 with idx_o=0 at cycle N+1.
REQ-024 A beat transfers when data_val_o and ready_i are both 1; on a transfer the beat's count SHALL be added to the running sum and idx SHALL increment.
REQ-025 With data_val_o=1 and ready_i=0, all beat outputs SHALL hold stable.
REQ-026 The transfer of the last beat SHALL move the FSM to FINISH.
REQ-027 FINISH SHALL last one cycle with done_o=1 and clear_o=1, then return to IDLE.
REQ-028 total_o SHALL equal the exact sum of all bins while done_o=1 and hold that value until the next start; the sum width is sufficient, so no overflow is possible.
REQ-029 A latched max_num_i >= BOUND_NUM SHALL never assert is_max_o; the stream SHALL otherwise proceed normally.
REQ-030 With ready_i held at 1, a full stream SHALL take BOUND_NUM+1 cycles from the first beat to the done_o pulse.
REQ-031 Outside SEND, data_val_o, is_max_o and last_o SHALL be 0.
REQ-032 busy_o SHALL be 1 in SEND and FINISH.

Reset
REQ-033 reset=1 SHALL force IDLE on the same clock edge and zero the following: idx, running sum, total_o, data_val_o, done_o, clear_o, busy_o and all shadow registers.
REQ-034 A reset during SEND or FINISH SHALL abort the stream and SHALL NOT emit clear_o or done_o.

Structure
REQ-035 The FSM state encoding and the default parameter values SHALL live in the shared histogram package used with the accumulator.
REQ-036 No sub-module is required; the shadow bank and the bin mux stay inline.

Verification
REQ-037 Scenario: bins i=i+1, max_num_i=31, ready_i=1, start pulse -> 32 beats with counts 1..32; is_max_o only on idx 31; last_o only on idx 31; total_o=528; done_o and clear_o pulse once, 33 cycles after the first beat.
REQ-038 Scenario: ready_i toggled 1/0 every cycle -> no beat lost or duplicated; outputs stable during stalls; total_o still correct.
REQ-039 Scenario: arr_i changed and start_i re-pulsed mid-stream -> streamed values match the first snapshot; the second start is ignored.
REQ-040 Scenario: reset asserted at beat 10 -> next cycle IDLE with all outputs 0; no clear_o; a new start streams from idx 0.
REQ-041 Scenario: all bins 16'hFFFF, max_num_i=5 -> total_o=32*65535=2097120; is_max_o only on idx 5.
REQ-042 Scenario: max_num_i=31 with BOUND_NUM=16, BOUND_NUM_WIDTH=5 -> 16 beats; is_max_o never asserted.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared histogram definitions: readout FSM encoding and default sizes.
// Used by the accumulator and by the readout streamer.
package hist_pkg;

   localparam int HIST_DATA_WIDTH      = 16;
   localparam int HIST_BOUND_NUM       = 32;
   localparam int HIST_BOUND_NUM_WIDTH = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      FINISH = 2'd2
   } rd_state_e;

endpackage

// File: rtl/hist_readout.sv
// Histogram readout: snapshots all bins on start and streams them
// one beat per accepted handshake, then pulses done/clear.
module hist_readout
   import hist_pkg::*;
#(
   parameter int DATA_WIDTH      = HIST_DATA_WIDTH,
   parameter int BOUND_NUM       = HIST_BOUND_NUM,
   parameter int BOUND_NUM_WIDTH = HIST_BOUND_NUM_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start_i,
   input  logic [DATA_WIDTH*BOUND_NUM-1:0]      arr_i,
   input  logic [BOUND_NUM_WIDTH-1:0]           max_num_i,
   input  logic                                 ready_i,
   output logic                                 data_val_o,
   output logic [DATA_WIDTH-1:0]                data_o,
   output logic [BOUND_NUM_WIDTH-1:0]           idx_o,
   output logic                                 is_max_o,
   output logic                                 last_o,
   output logic                                 busy_o,
   output logic [DATA_WIDTH+BOUND_NUM_WIDTH-1:0] total_o,
   output logic                                 done_o,
   output logic                                 clear_o
);

   localparam int SW = DATA_WIDTH + BOUND_NUM_WIDTH;
   localparam logic [BOUND_NUM_WIDTH-1:0] LAST_IDX =
      BOUND_NUM_WIDTH'(BOUND_NUM - 1);

   rd_state_e                  state_q;
   logic [DATA_WIDTH-1:0]      shadow_q [BOUND_NUM];
   logic [BOUND_NUM_WIDTH-1:0] idx_q;
   logic [BOUND_NUM_WIDTH-1:0] idx_d;
   logic [BOUND_NUM_WIDTH-1:0] max_q;
   logic [SW-1:0]              sum_q;
   logic [SW-1:0]              sum_d;
   logic [SW-1:0]              total_q;
   logic                       val_q;
   logic                       done_q;
   logic                       clear_q;
   logic                       busy_q;

   logic [DATA_WIDTH-1:0]      beat;
   logic                       xfer;
   logic                       at_last;

   assign beat    = shadow_q[idx_q];
   assign xfer    = val_q & ready_i;
   assign at_last = (idx_q == LAST_IDX);
   assign sum_d   = sum_q + SW'(beat);
   assign idx_d   = idx_q + BOUND_NUM_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         max_q   <= '0;
         sum_q   <= '0;
         total_q <= '0;
         val_q   <= 1'b0;
         done_q  <= 1'b0;
         clear_q <= 1'b0;
         busy_q  <= 1'b0;
         for (int i = 0; i < BOUND_NUM; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         done_q  <= 1'b0;
         clear_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  for (int i = 0; i < BOUND_NUM; i++) begin
                     shadow_q[i] <= arr_i[i*DATA_WIDTH +: DATA_WIDTH];
                  end
                  max_q   <= max_num_i;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  val_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (xfer) begin
                  sum_q <= sum_d;
                  if (at_last) begin
                     // publish the completed sum together with done
                     total_q <= sum_d;
                     idx_q   <= '0;
                     val_q   <= 1'b0;
                     done_q  <= 1'b1;
                     clear_q <= 1'b1;
                     state_q <= FINISH;
                  end else begin
                     idx_q <= idx_d;
                  end
               end
            end
            FINISH: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               val_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // idx never exceeds BOUND_NUM-1, so an out-of-range max never matches
   assign data_val_o = val_q;
   assign data_o     = val_q ? beat : '0;
   assign idx_o      = idx_q;
   assign is_max_o   = val_q & (idx_q == max_q);
   assign last_o     = val_q & at_last;
   assign busy_o     = busy_q;
   assign total_o    = total_q;
   assign done_o     = done_q;
   assign clear_o    = clear_q;

endmodule

// File: tb/tb_hist_readout.sv
// Directed bench for hist_readout: full streams, stalls, restart,
// reset abort, saturated bins and a 16-bin build.
module tb_hist_readout;

   localparam int DW  = 16;
   localparam int BN  = 32;
   localparam int BW  = 5;
   localparam int SW  = DW + BW;
   localparam int BN2 = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start_i;
   logic [DW*BN-1:0]  arr_i;
   logic [BW-1:0]     max_num_i;
   logic              ready_i;
   logic              data_val_o;
   logic [DW-1:0]     data_o;
   logic [BW-1:0]     idx_o;
   logic              is_max_o;
   logic              last_o;
   logic              busy_o;
   logic [SW-1:0]     total_o;
   logic              done_o;
   logic              clear_o;

   logic              s_start;
   logic [DW*BN2-1:0] s_arr;
   logic [BW-1:0]     s_max;
   logic              s_ready;
   logic              s_val;
   logic [DW-1:0]     s_data;
   logic [BW-1:0]     s_idx;
   logic              s_is_max;
   logic              s_last;
   logic              s_busy;
   logic [SW-1:0]     s_total;
   logic              s_done;
   logic              s_clear;

   int checks = 0;
   int errors = 0;
   int clear_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (clear_o) clear_cnt++;

   hist_readout #(
      .DATA_WIDTH(DW), .BOUND_NUM(BN), .BOUND_NUM_WIDTH(BW)
   ) dut (
      .clk(clk), .reset(reset), .start_i(start_i),
      .arr_i(arr_i), .max_num_i(max_num_i), .ready_i(ready_i),
      .data_val_o(data_val_o), .data_o(data_o), .idx_o(idx_o),
      .is_max_o(is_max_o), .last_o(last_o), .busy_o(busy_o),
      .total_o(total_o), .done_o(done_o), .clear_o(clear_o)
   );

   hist_readout #(
      .DATA_WIDTH(DW), .BOUND_NUM(BN2), .BOUND_NUM_WIDTH(BW)
   ) dut16 (
      .clk(clk), .reset(reset), .start_i(s_start),
      .arr_i(s_arr), .max_num_i(s_max), .ready_i(s_ready),
      .data_val_o(s_val), .data_o(s_data), .idx_o(s_idx),
      .is_max_o(s_is_max), .last_o(s_last), .busy_o(s_busy),
      .total_o(s_total), .done_o(s_done), .clear_o(s_clear)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int bin_val(input int mode, input int i);
      case (mode)
         0:       return i + 1;
         1:       return 65535;
         default: return 1000 + 7 * i;
      endcase
   endfunction

   function automatic logic [DW*BN-1:0] mk_arr(input int mode);
      logic [DW*BN-1:0] a;
      int v;
      a = '0;
      for (int i = 0; i < BN; i++) begin
         v = bin_val(mode, i);
         a[i*DW +: DW] = v[DW-1:0];
      end
      return a;
   endfunction

   task automatic run_stream(input int mode, input int maxn,
                             input bit toggle, input int restart_at);
      int k, cyc, sum, c0;
      bit stall_q, restarted;
      logic [DW-1:0] pd;
      logic [BW-1:0] pi;
      k = 0; cyc = 0; sum = 0;
      stall_q = 0; restarted = 0;
      pd = '0; pi = '0;
      for (int i = 0; i < BN; i++) sum += bin_val(mode, i);
      arr_i     = mk_arr(mode);
      max_num_i = maxn[BW-1:0];
      ready_i   = 1'b1;
      c0        = clear_cnt;
      start_i   = 1'b1;
      tick();
      start_i = 1'b0;
      chk("first_val", data_val_o, 1);
      chk("first_idx", idx_o, 0);
      chk("first_busy", busy_o, 1);
      while (!done_o && cyc < 400) begin
         chk("val_hold", data_val_o, 1);
         if (stall_q) begin
            chk("stall_data", data_o, pd);
            chk("stall_idx", idx_o, pi);
         end
         if (ready_i) begin
            chk("idx", idx_o, k);
            chk("data", data_o, bin_val(mode, k));
            chk("is_max", is_max_o, k == maxn);
            chk("last", last_o, k == BN - 1);
            k++;
         end
         stall_q = !ready_i;
         pd = data_o;
         pi = idx_o;
         if (k == restart_at && !restarted) begin
            arr_i     = mk_arr(2);
            max_num_i = '0;
            start_i   = 1'b1;
            restarted = 1;
         end
         tick();
         cyc++;
         start_i = 1'b0;
         if (toggle) ready_i = !ready_i;
      end
      chk("done", done_o, 1);
      chk("clear", clear_o, 1);
      chk("beats", k, BN);
      chk("total", total_o, sum);
      chk("fin_val", data_val_o, 0);
      chk("fin_busy", busy_o, 1);
      if (!toggle) chk("cycles", cyc + 1, BN + 1);
      tick();
      chk("done_pulse", done_o, 0);
      chk("clear_pulse", clear_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("total_hold", total_o, sum);
      chk("clear_cnt", clear_cnt - c0, 1);
   endtask

   initial begin
      int c0, cyc, nm, beats;
      reset     = 1'b1;
      start_i   = 1'b0;
      ready_i   = 1'b0;
      arr_i     = '0;
      max_num_i = '0;
      s_start   = 1'b0;
      s_arr     = '0;
      s_max     = '0;
      s_ready   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_val", data_val_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_total", total_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_clear", clear_o, 0);
      chk("rst_idx", idx_o, 0);

      run_stream(0, 31, 0, -1);
      run_stream(2, 7, 1, -1);
      run_stream(0, 3, 0, 12);

      arr_i     = mk_arr(0);
      max_num_i = 5'd31;
      ready_i   = 1'b1;
      start_i   = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("pre_rst_idx", idx_o, 10);
      c0    = clear_cnt;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_val", data_val_o, 0);
      chk("abort_busy", busy_o, 0);
      chk("abort_done", done_o, 0);
      chk("abort_clear", clear_o, 0);
      chk("abort_idx", idx_o, 0);
      chk("abort_data", data_o, 0);
      chk("abort_total", total_o, 0);
      chk("abort_last", last_o, 0);
      tick();
      tick();
      chk("abort_no_clr", clear_cnt - c0, 0);
      chk("abort_idle", busy_o, 0);

      run_stream(1, 5, 0, -1);

      for (int i = 0; i < BN2; i++) s_arr[i*DW +: DW] = DW'(i + 1);
      s_max   = 5'd31;
      s_ready = 1'b1;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      cyc = 0; nm = 0; beats = 0;
      while (!s_done && cyc < 100) begin
         if (s_is_max) nm++;
         if (s_val && s_ready) begin
            chk("s_idx", s_idx, beats);
            beats++;
         end
         tick();
         cyc++;
      end
      chk("s_done", s_done, 1);
      chk("s_beats", beats, BN2);
      chk("s_no_max", nm, 0);
      chk("s_total", s_total, 136);
      chk("s_cycles", cyc + 1, BN2 + 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
